// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel pipeline (window generator, core, top level).
package sobel_pkg;

  localparam int unsigned DEF_IMG_WIDTH   = 8;
  localparam int unsigned DEF_IMG_HEIGHT  = 8;
  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_COORD_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Handshake bundles around the window generator: raster pixel stream in, 3x3 window stream out.
interface sobel_pix_if
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface sobel_win_if
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned COORD_WIDTH = DEF_COORD_WIDTH
);
  logic                   valid;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  p00, p01, p02;
  logic [DATA_WIDTH-1:0]  p10, p11, p12;
  logic [DATA_WIDTH-1:0]  p20, p21, p22;
  logic [COORD_WIDTH-1:0] row;
  logic [COORD_WIDTH-1:0] col;

  modport master (output valid, output p00, output p01, output p02, output p10, output p11,
                  output p12, output p20, output p21, output p22, output row, output col,
                  input ready);
  modport slave  (input valid, input p00, input p01, input p02, input p10, input p11,
                  input p12, input p20, input p21, input p22, input row, input col,
                  output ready);
endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of storage: synchronous write, combinational read of the old value at the same address.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_IMG_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_COORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_c
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wr_data_i;
  end

  assign rd_data_c = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two lines and emits one neighbourhood per interior pixel.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  sobel_pix_if.slave  pix_i,
  sobel_win_if.master win_o,
  output logic        frame_done_o
);
  localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] ONE      = COORD_WIDTH'(1);
  localparam logic [COORD_WIDTH-1:0] TWO      = COORD_WIDTH'(2);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  state_e                 state_q, state_d;
  logic [COORD_WIDTH-1:0] in_row_q, in_row_d, in_col_q, in_col_d;
  pix_t [2:0][1:0]        sr_q, sr_d;     // [row offset][0 = left, 1 = middle column]
  pix_t [2:0][2:0]        win_q, win_d;   // [row offset][column offset]
  logic [COORD_WIDTH-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;

  logic                   pix_ready_c, accept_c, win_hs_c;
  pix_t                   top_c, mid_c;
  pix_t [2:0]             col_c;

  // Two chained lines: lb0 holds the previous row, lb1 the one before it.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(COORD_WIDTH)) u_lb0 (
    .clk       (clk),
    .we_i      (accept_c),
    .addr_i    (in_col_q),
    .wr_data_i (pix_i.data),
    .rd_data_c (mid_c)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(COORD_WIDTH)) u_lb1 (
    .clk       (clk),
    .we_i      (accept_c),
    .addr_i    (in_col_q),
    .wr_data_i (mid_c),
    .rd_data_c (top_c)
  );

  assign pix_ready_c = (state_q == STREAM) && (!win_valid_q || win_o.ready);
  assign accept_c    = pix_i.valid && pix_ready_c;
  assign win_hs_c    = win_valid_q && win_o.ready;
  assign col_c[0]    = top_c;
  assign col_c[1]    = mid_c;
  assign col_c[2]    = pix_i.data;

  always_comb begin
    state_d      = state_q;
    in_row_d     = in_row_q;
    in_col_d     = in_col_q;
    sr_d         = sr_q;
    win_d        = win_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = win_valid_q;

    if (win_hs_c) win_valid_d = 1'b0;

    if (accept_c) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = col_c[r];
      end
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = in_row_q + ONE;
      end else begin
        in_col_d = in_col_q + ONE;
      end
      // A reload in the same cycle as a handshake replaces the window without a bubble.
      if (in_row_q >= TWO && in_col_q >= TWO) begin
        for (int r = 0; r < 3; r++) begin
          win_d[r][0] = sr_q[r][0];
          win_d[r][1] = sr_q[r][1];
          win_d[r][2] = col_c[r];
        end
        win_row_d   = in_row_q - ONE;
        win_col_d   = in_col_q - ONE;
        win_valid_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = STREAM;
          in_row_d = '0;
          in_col_d = '0;
        end
      end
      STREAM: if (accept_c && in_row_q == LAST_ROW && in_col_q == LAST_COL) state_d = DRAIN;
      DRAIN:  if (win_hs_c) state_d = DONE;
      DONE:   state_d = IDLE;
    endcase

    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_row_q     <= '0;
      in_col_q     <= '0;
      sr_q         <= '0;
      win_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      sr_q         <= sr_d;
      win_q        <= win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_i.ready  = pix_ready_c;
  assign win_o.valid  = win_valid_q;
  assign win_o.p00    = win_q[0][0];
  assign win_o.p01    = win_q[0][1];
  assign win_o.p02    = win_q[0][2];
  assign win_o.p10    = win_q[1][0];
  assign win_o.p11    = win_q[1][1];
  assign win_o.p12    = win_q[1][2];
  assign win_o.p20    = win_q[2][0];
  assign win_o.p21    = win_q[2][1];
  assign win_o.p22    = win_q[2][2];
  assign win_o.row    = win_row_q;
  assign win_o.col    = win_col_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised bench for sobel_window_gen: every handshaken window is compared with one cut from a stored image.
module tb_sobel_window_gen;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned VW = 9 * 8 + 6;

  logic clk;
  logic rst;
  logic start;
  logic frame_done;
  logic rdy_rand;

  int n_tests;
  int n_fail;
  int n_done;
  int n_done_total;

  logic [7:0]    img [H][W];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] got_q [$];

  sobel_pix_if #(.DATA_WIDTH(8)) pix ();
  sobel_win_if #(.DATA_WIDTH(8), .COORD_WIDTH(3)) win ();

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .COORD_WIDTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .pix_i        (pix),
    .win_o        (win),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {win.p00, win.p01, win.p02, win.p10, win.p11, win.p12,
            win.p20, win.p21, win.p22, win.row, win.col};
  endfunction

  // Reference window: the 3x3 neighbourhood of (r, c) read straight out of the image.
  function automatic logic [VW-1:0] model_vec(input int r, input int c);
    logic [71:0] p = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        p = {p[63:0], img[r-1+dr][c-1+dc]};
    return {p, 3'(r), 3'(c)};
  endfunction

  // pat 0: 8r+c, pat 1: all 0xFF, pat 2: single 0xFF at (3,3)
  task automatic load_frame(input int pat);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        case (pat)
          0:       img[r][c] = 8'(8 * r + c);
          1:       img[r][c] = 8'hFF;
          default: img[r][c] = (r == 3 && c == 3) ? 8'hFF : 8'h00;
        endcase
    exp_q.delete();
    got_q.delete();
    for (int r = 1; r < int'(H) - 1; r++)
      for (int c = 1; c < int'(W) - 1; c++)
        exp_q.push_back(model_vec(r, c));
    n_done = 0;
  endtask

  task automatic drive(input int n_pix, input int gap_pct, input int start_at);
    int  idx = 0;
    int  budget = 0;
    bit  acc;
    bit  pulsed = 1'b0;
    while (idx < n_pix && budget < 3000) begin
      pix.valid = ($urandom_range(99) >= 32'(gap_pct));
      pix.data  = img[idx / int'(W)][idx % int'(W)];
      start     = (idx == start_at) && !pulsed;
      if (start) pulsed = 1'b1;
      @(negedge clk);
      acc = pix.valid && pix.ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    pix.valid = 1'b0;
    start     = 1'b0;
    check("drive_progress", VW'(idx), VW'(n_pix));
  endtask

  task automatic run_frame(input int pat, input bit rr, input int gap_pct, input int start_at,
                           input string tag);
    int b = 0;
    load_frame(pat);
    rdy_rand = rr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(int'(W * H), gap_pct, start_at);
    while (n_done == 0 && b < 400) begin
      @(posedge clk);
      #1;
      b++;
    end
    check({tag, "_frame_done"}, VW'(n_done), VW'(1));
    check({tag, "_win_count"}, VW'(got_q.size()), VW'(36));
    check({tag, "_exp_left"}, VW'(exp_q.size()), VW'(0));
  endtask

  task automatic check_ramp(input string tag);
    int bad = 0;
    check({tag, "_first"}, got_q[0],
          {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 3'd1, 3'd1});
    check({tag, "_row1_end"}, got_q[5],
          {8'd5, 8'd6, 8'd7, 8'd13, 8'd14, 8'd15, 8'd21, 8'd22, 8'd23, 3'd1, 3'd6});
    check({tag, "_row2_start"}, got_q[6],
          {8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26, 3'd2, 3'd1});
    check({tag, "_last"}, got_q[35],
          {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63, 3'd6, 3'd6});
    foreach (got_q[i]) if (got_q[i][2:0] == 3'd0 || got_q[i][2:0] == 3'd7) bad++;
    check({tag, "_col_range"}, VW'(bad), VW'(0));
  endtask

  // Ready generator for the window side.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      win.ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Compare process: window handshakes, output hold under stall, pix_ready back-pressure, frame_done.
  initial begin
    logic [VW-1:0] snap;
    bit            prev_stall;
    bit            prev_done;
    snap       = '0;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) check("hold_while_stalled", dut_vec(), snap);
        if (win.valid && !win.ready) check("pix_ready_while_full", VW'(pix.ready), VW'(0));
        if (win.valid && win.ready) begin
          got_q.push_back(dut_vec());
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_window: got %h expected none", dut_vec());
          end else begin
            check("window", dut_vec(), exp_q.pop_front());
          end
        end
        if (frame_done) begin
          n_done++;
          n_done_total++;
          check("done_before_last_window", VW'(exp_q.size()), VW'(0));
          check("done_single_pulse", VW'(prev_done), VW'(0));
        end
        prev_stall = win.valid && !win.ready;
        prev_done  = frame_done;
        snap       = dut_vec();
      end
    end
  end

  initial begin
    int ff_hits;
    n_tests      = 0;
    n_fail       = 0;
    n_done       = 0;
    n_done_total = 0;
    rst          = 1'b1;
    start        = 1'b0;
    rdy_rand     = 1'b0;
    pix.valid    = 1'b0;
    pix.data     = '0;
    win.ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", VW'(pix.ready), VW'(0));
    check("rst_win_valid", VW'(win.valid), VW'(0));
    check("rst_frame_done", VW'(frame_done), VW'(0));
    check("rst_window", dut_vec(), '0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    pix.valid = 1'b1;
    @(negedge clk);
    check("idle_pix_ready", VW'(pix.ready), VW'(0));
    @(posedge clk);
    #1;
    pix.valid = 1'b0;

    load_frame(0);
    check("model_pin", model_vec(1, 1),
          {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 3'd1, 3'd1});

    run_frame(0, 1'b0, 0, -1, "cont");
    check_ramp("cont");
    run_frame(0, 1'b1, 30, -1, "rand");
    check_ramp("rand");
    run_frame(0, 1'b1, 20, 30, "start_mid");
    check_ramp("start_mid");
    run_frame(0, 1'b0, 0, -1, "b2b");
    check_ramp("b2b");

    // Abort after 20 pixels, then a fresh frame of all 0xFF.
    load_frame(0);
    rdy_rand = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drive(20, 0, -1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_win_valid", VW'(win.valid), VW'(0));
    check("abort_pix_ready", VW'(pix.ready), VW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_no_done", VW'(n_done), VW'(0));
    check("abort_idle", VW'(win.valid), VW'(0));
    @(posedge clk);
    #1;
    run_frame(1, 1'b1, 25, -1, "ff");
    check("ff_first", got_q[0], {72'hFF_FFFF_FFFF_FFFF_FFFF, 3'd1, 3'd1});
    check("ff_last", got_q[35], {72'hFF_FFFF_FFFF_FFFF_FFFF, 3'd6, 3'd6});

    run_frame(2, 1'b1, 10, -1, "impulse");
    check("impulse_2_2", got_q[7], {64'h0, 8'hFF, 3'd2, 3'd2});
    check("impulse_3_3", got_q[14], {32'h0, 8'hFF, 32'h0, 3'd3, 3'd3});
    check("impulse_4_4", got_q[21], {8'hFF, 64'h0, 3'd4, 3'd4});
    ff_hits = 0;
    foreach (got_q[i]) if (got_q[i][VW-1:6] != '0) ff_hits++;
    check("impulse_hits", VW'(ff_hits), VW'(9));

    check("done_total", VW'(n_done_total), VW'(6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the Sobel core. It accepts a raster-order pixel stream over a valid/ready handshake and buffers two image lines internally. For every interior pixel it emits the nine neighbourhood pixels plus the centre coordinates, so the core needs no random-access image memory. Throughput is one window per cycle when neither side stalls.

## Interface
- IMG_WIDTH, 8: pixels per line (≥3).
- IMG_HEIGHT, 8: lines per frame (≥3).
- DATA_WIDTH, 8: pixel width.
- COORD_WIDTH, 3: width of row/column coordinates (≥ clog2 of max(IMG_WIDTH, IMG_HEIGHT)).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; ignored unless idle.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  block accepts pix_data this cycle.
- pix_data  in  DATA_WIDTH  pixel, raster order, row 0 col 0 first.
- win_valid  out  1  window outputs valid.
- win_ready  in  1  downstream accepts window.
- win_p00..win_p22  out  DATA_WIDTH each  window; pRC means R = row offset (0 = top), C = column offset (0 = left).
- win_row, win_col  out  COORD_WIDTH  centre pixel coordinates.
- frame_done  out  1  one-cycle pulse after the last window is taken.

## Operation
- States:
  - IDLE: pix_ready=0; start -> STREAM and clears in_row and in_col.
  - STREAM: accepts pixels; after the last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted -> DRAIN.
  - DRAIN: waits until the final window handshakes -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- Pixel accept is pix_valid && pix_ready. On accept at (r, c):
  - top = lb1[c], mid = lb0[c], bot = pix_data (read before write).
  - The 3x3 shift register moves left one column; the new column is {top, mid, bot}.
  - lb1[c] <= lb0[c]; lb0[c] <= pix_data.
  - in_col increments and wraps to 0 at IMG_WIDTH-1; in_row increments on wrap.
- If r ≥ 2 and c ≥ 2, the accept also loads the output register: win_valid <= 1, win_row = r-1, win_col = c-1.
- Columns 0–1 of each row hold stale data from the previous row but are never emitted.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2), i.e. 36 at default parameters.
- Output register clears on a win_valid && win_ready handshake unless reloaded in the same cycle.
- start during STREAM, DRAIN or DONE is ignored.
- Pixels offered in IDLE or DRAIN are not accepted (pix_ready=0).

## Timing
- Reset values: pix_ready=0, win_valid=0, frame_done=0, all win_p*=0, win_row=win_col=0, state IDLE, counters 0. Line-buffer contents are not reset.
- pix_ready = (state==STREAM) && (!win_valid || win_ready). This is combinational from win_ready; no accept is lost when the output is full.
- Latency: a window is valid the cycle after the handshake of its bottom-right pixel.
- win_p*, win_row and win_col stay stable while win_valid && !win_ready.
- A simultaneous output handshake and new load replaces the window with no bubble.
- frame_done is asserted the cycle after the final window handshake. start is accepted again from the following cycle.
- Reset mid-frame aborts immediately to IDLE: partial windows are discarded, no frame_done. The next start begins a fresh frame.

## Structure
- Shared package sobel_pkg:
  - state enum {IDLE, STREAM, DRAIN, DONE};
  - default IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH and COORD_WIDTH constants, shared with the core and its top level.
- Sub-module sobel_line_buffer: one IMG_WIDTH x DATA_WIDTH array with synchronous write and asynchronous read-before-write. It is instantiated twice (lb0, lb1) and the two instances are chained.

## Test plan
All scenarios use an 8x8 image with pixel(r,c) = 8r+c unless stated.
- Continuous stream, win_ready=1:
  - first window win_row=1, win_col=1, p00..p22 = 0,1,2,8,9,10,16,17,18;
  - last window (6,6) = 45,46,47,53,54,55,61,62,63;
  - exactly 36 windows; frame_done pulses once.
- win_ready toggled randomly, pix_valid gapped:
  - identical 36-window sequence;
  - outputs held stable while stalled;
  - no pix_ready while win_valid && !win_ready.
- Row boundary: after window (1,6), the next window is (2,1) = 8,9,10,16,17,18,24,25,26; no window is emitted with col 0 or 7.
- rst asserted after 20 pixels, then start with an all-0xFF image: 36 windows, all p = 0xFF, no frame_done before restart.
- start pulsed during STREAM: ignored, counts unaffected. Back-to-back frames: second frame's first window = 0,1,2,8,9,10,16,17,18.
- pix_data=0xFF at centre (3,3) only, rest 0: the 9 windows centred at rows 2–4, cols 2–4 each contain exactly one 0xFF, at the correct offset.
